instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle fetch/decode/execute controller for the Jac1-8 8-bit core. Owns the program counter and instruction register, and fetches 16-bit instructions from program memory over a req/ack handshake. Feeds the latched instruction to the combinational decoder and converts the decoder's level enables into single-cycle commit strobes for the register file, status register and PC.

## Interface
- `PC_WIDTH`, 8, program counter / program memory address width
- `PROGRAM_DataWidth`, 16, instruction width
- `DataWidth`, 8, width of decoder `literal_adr`
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `run`  in  1  level; 1 = free-running execution, 0 = stop at next instruction boundary
- `mem_req`  out  1  program memory read request
- `mem_addr`  out  PC_WIDTH  read address, always equals `pc`
- `mem_ack`  in  1  read data valid this cycle
- `mem_rdata`  in  PROGRAM_DataWidth  instruction word
- `instruction`  out  PROGRAM_DataWidth  instruction register, drives decoder
- `wr_en`, `stat_wr_en`, `cnt_wr_en`  in  1 each  decoder enables
- `literal_adr`  in  DataWidth  decoder branch target
- `reg_wr_strobe`  out  1  register-file write commit
- `stat_wr_strobe`  out  1  status register write commit
- `pc`  out  PC_WIDTH  program counter
- `instr_done`  out  1  one-cycle pulse at instruction retire
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, FETCH, DECODE, EXEC.
- IDLE:
  - `mem_req`=0, all strobes 0.
  - `run`=1 -> FETCH.
- FETCH:
  - `mem_req`=1, `mem_addr`=`pc`.
  - On `mem_ack`=1: IR <= `mem_rdata`, -> DECODE.
  - `mem_ack`=0: stay in FETCH, request held, no timeout.
- DECODE:
  - IR stable; one cycle for decoder and register-file reads to settle.
  - -> EXEC unconditionally.
- EXEC (exactly one cycle):
  - `reg_wr_strobe`=`wr_en`, `stat_wr_strobe`=`stat_wr_en`, `instr_done`=1.
  - `pc` <= `cnt_wr_en` ? `literal_adr` : `pc`+1.
  - Next state: FETCH if `run`=1, else IDLE.
- PC arithmetic: modulo 2^PC_WIDTH; 0xFF+1 wraps to 0x00, no flag. If `DataWidth` < `PC_WIDTH`, `literal_adr` is zero-extended.
- `mem_ack` outside FETCH is ignored; IR is unchanged.
- `run` is sampled only in IDLE and at the EXEC exit. Deasserting `run` mid-instruction lets the current instruction complete.
- NOP and reserved opcodes pass through normally: the decoder enables are 0, so only the PC increments.
- Conditional branches (IFZ/IFNZ/…): the sequencer acts solely on `cnt_wr_en`. Taken/not-taken is resolved by the decoder from status.

## Timing
- Reset values:
  - state IDLE; `pc`=0, `instruction`=0 (NOP).
  - `mem_req`=0, `reg_wr_strobe`=0, `stat_wr_strobe`=0, `instr_done`=0, `busy`=0.
- Reset asserted in any state aborts immediately. A pending fetch is dropped, no strobe is issued, and the PC returns to 0.
- Zero-wait memory (`mem_ack` in the first FETCH cycle): 3 cycles per instruction.
- N wait cycles add N cycles.
- All outputs are registered, or decoded from state only. `reg_wr_strobe` and `stat_wr_strobe` are combinational AND of EXEC with the decoder enables.
- First `mem_req` appears 1 cycle after `run` is seen high in IDLE.

## Configuration
- `SEQ_SINGLE_STEP_EN` defined:
  - Adds input `step` (1 bit).
  - In IDLE with `run`=0, a rising `step` (edge-detected internally) executes exactly one instruction, then returns to IDLE.
  - `step` held high does not repeat.
  - `step` is ignored while `busy`=1 or `run`=1.
- Undefined: no `step` port; only `run` starts execution.

## Test plan
- Reset/idle: assert `reset`, release with `run`=0 -> `pc`=0, `instruction`=0, `mem_req`=0, `busy`=0 for 10 cycles.
- Sequential fetch, zero-wait: memory[0..2] = ADD r1,r2 / VAL r3,0xA5 / NOP; `run`=1.
  - `instr_done` every 3rd cycle; PC 0->1->2->3.
  - `reg_wr_strobe` in EXEC of instructions 0 and 1 only.
  - `stat_wr_strobe` only for ADD.
- Wait states: `mem_ack` delayed 4 cycles on PC=1 -> `mem_req` held 5 cycles with `mem_addr`=1; instruction period 7 cycles; no strobes during wait.
- Branch and wrap:
  - GOTO 0x3F at PC 0 -> next fetch address 0x3F.
  - Non-branch at PC 0xFF -> next fetch address 0x00.
- Reset mid-operation: assert `reset` during FETCH with `mem_ack`=0, then during EXEC -> strobes drop to 0 at once; `pc`=0 after release; no write commit observed.
- Single step (`SEQ_SINGLE_STEP_EN`), `run`=0:
  - One `step` pulse -> exactly one `instr_done` and PC+1.
  - `step` held high 20 cycles -> still one instruction.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the Jac1-8 core.
// Owns PC and IR, fetches instructions over a req/ack handshake and turns the
// decoder's level enables into single-cycle commit strobes.
// Optional feature: define SEQ_SINGLE_STEP_EN to add a `step` input that runs
// one instruction per rising edge while `run` is low.
module instr_sequencer #(
  parameter int unsigned PC_WIDTH          = 8,
  parameter int unsigned PROGRAM_DataWidth = 16,
  parameter int unsigned DataWidth         = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                         step,
`endif
  output logic                         mem_req,
  output logic [PC_WIDTH-1:0]          mem_addr,
  input  logic                         mem_ack,
  input  logic [PROGRAM_DataWidth-1:0] mem_rdata,
  output logic [PROGRAM_DataWidth-1:0] instruction,
  input  logic                         wr_en,
  input  logic                         stat_wr_en,
  input  logic                         cnt_wr_en,
  input  logic [DataWidth-1:0]         literal_adr,
  output logic                         reg_wr_strobe,
  output logic                         stat_wr_strobe,
  output logic [PC_WIDTH-1:0]          pc,
  output logic                         instr_done,
  output logic                         busy
);

  typedef enum logic [1:0] {StIdle, StFetch, StDecode, StExec} state_e;

  state_e                         state_q;
  logic [PC_WIDTH-1:0]            pc_q;
  logic [PROGRAM_DataWidth-1:0]   ir_q;
  logic                           mem_req_q;
  logic                           instr_done_q;
  logic                           busy_q;
  logic                           start;
  logic [PC_WIDTH-1:0]            branch_target;

  // Size cast zero-extends (or truncates) the decoder target to PC width.
  assign branch_target = PC_WIDTH'(literal_adr);

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;
  logic step_rise;

  // Edge detector for step; runs every cycle so edges during busy are consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  assign step_rise = step & ~step_q;
  assign start     = run | step_rise;
`else
  assign start = run;
`endif

  // Main FSM; control outputs are registered alongside the state they decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      ir_q         <= '0;
      mem_req_q    <= 1'b0;
      instr_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StFetch;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        StFetch: begin
          if (mem_ack) begin
            ir_q      <= mem_rdata;
            state_q   <= StDecode;
            mem_req_q <= 1'b0;
          end
        end
        StDecode: begin
          state_q      <= StExec;
          instr_done_q <= 1'b1;
        end
        StExec: begin
          instr_done_q <= 1'b0;
          pc_q         <= cnt_wr_en ? branch_target : pc_q + PC_WIDTH'(1);
          // run is sampled here so a deasserted run still lets this instruction retire.
          if (run) begin
            state_q   <= StFetch;
            mem_req_q <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q      <= StIdle;
          mem_req_q    <= 1'b0;
          instr_done_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  // Commit strobes are gated directly by EXEC so reset kills them immediately.
  assign reg_wr_strobe  = (state_q == StExec) & wr_en;
  assign stat_wr_strobe = (state_q == StExec) & stat_wr_en;

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instruction = ir_q;
  assign instr_done  = instr_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer with a behavioural memory/decoder model.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] instruction;
  logic        wr_en, stat_wr_en, cnt_wr_en;
  logic [7:0]  literal_adr;
  logic        reg_wr_strobe, stat_wr_strobe;
  logic [7:0]  pc;
  logic        instr_done, busy;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [256];
  int          waits [256];

  // Toy ISA: [15:12] opcode. 0 NOP, 1 ADD (reg+stat), 2 VAL (reg), 3 GOTO lit, others reserved.
  function automatic logic f_wr(input logic [15:0] w);
    return (w[15:12] == 4'h1) || (w[15:12] == 4'h2);
  endfunction
  function automatic logic f_stat(input logic [15:0] w);
    return w[15:12] == 4'h1;
  endfunction
  function automatic logic f_cnt(input logic [15:0] w);
    return w[15:12] == 4'h3;
  endfunction

  assign wr_en       = f_wr(instruction);
  assign stat_wr_en  = f_stat(instruction);
  assign cnt_wr_en   = f_cnt(instruction);
  assign literal_adr = instruction[7:0];

  instr_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
`ifdef SEQ_SINGLE_STEP_EN
    .step           (step),
`endif
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instruction    (instruction),
    .wr_en          (wr_en),
    .stat_wr_en     (stat_wr_en),
    .cnt_wr_en      (cnt_wr_en),
    .literal_adr    (literal_adr),
    .reg_wr_strobe  (reg_wr_strobe),
    .stat_wr_strobe (stat_wr_strobe),
    .pc             (pc),
    .instr_done     (instr_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Memory responder: acks after waits[addr] request cycles; random junk acks when idle.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req && !reset) begin
        if (wcnt >= waits[mem_addr]) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          wcnt      = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 16'($urandom);
          wcnt++;
        end
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        wcnt      = 0;
      end
    end
  end

  task automatic clear_program();
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 16'h0000;
      waits[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    run   = 1'b0;
    step  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs n instructions from PC 0 (DUT must be idle after reset) against the model.
  task automatic run_prog(input int n, input string tag);
    logic [7:0]  pm;
    logic [15:0] iw;
    int          w;
    logic        exp_req;
    pm = 8'h00;
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < n; i++) begin
      iw = mem[pm];
      w  = waits[pm];
      for (int c = 1; c <= w + 2; c++) begin
        @(negedge clk);
        exp_req = (c <= w + 1);
        vectors++;
        if (instr_done !== 1'b0 || reg_wr_strobe !== 1'b0 || stat_wr_strobe !== 1'b0 ||
            busy !== 1'b1 || mem_req !== exp_req) begin
          miscompares++;
          $display("FAIL %s_ctrl instr %0d cyc %0d: got done=%b rs=%b ss=%b busy=%b req=%b, want 0 0 0 1 %b",
                   tag, i, c, instr_done, reg_wr_strobe, stat_wr_strobe, busy, mem_req, exp_req);
        end
        if (exp_req) begin
          vectors++;
          if (mem_addr !== pm) begin
            miscompares++;
            $display("FAIL %s_addr instr %0d: got %0h want %0h", tag, i, mem_addr, pm);
          end
        end
      end
      @(negedge clk);
      if (i == n - 1) run = 1'b0;
      vectors++;
      if (instr_done !== 1'b1 || pc !== pm || instruction !== iw ||
          reg_wr_strobe !== f_wr(iw) || stat_wr_strobe !== f_stat(iw) || mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_exec instr %0d: got done=%b pc=%0h ir=%0h rs=%b ss=%b req=%b, want 1 %0h %0h %b %b 0",
                 tag, i, instr_done, pc, instruction, reg_wr_strobe, stat_wr_strobe, mem_req,
                 pm, iw, f_wr(iw), f_stat(iw));
      end
      pm = f_cnt(iw) ? iw[7:0] : pm + 8'd1;
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || pc !== pm || instr_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_stop: got busy=%b req=%b pc=%0h done=%b, want 0 0 %0h 0",
               tag, busy, mem_req, pc, instr_done, pm);
    end
  endtask

  task automatic test_reset();
    clear_program();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (pc !== 8'h00 || instruction !== 16'h0000 || mem_req !== 1'b0 || busy !== 1'b0 ||
          instr_done !== 1'b0 || reg_wr_strobe !== 1'b0 || stat_wr_strobe !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: got pc=%0h ir=%0h req=%b busy=%b done=%b, want all 0",
                 c, pc, instruction, mem_req, busy, instr_done);
      end
    end
  endtask

  task automatic test_sequential();
    clear_program();
    mem[0] = 16'h1012;  // ADD r1,r2
    mem[1] = 16'h23A5;  // VAL r3,0xA5
    mem[2] = 16'h0000;  // NOP
    do_reset();
    run_prog(3, "seq");
  endtask

  task automatic test_wait_states();
    clear_program();
    mem[0] = 16'h2011;
    mem[1] = 16'h1034;
    mem[2] = 16'h0000;
    waits[1] = 4;
    do_reset();
    run_prog(3, "wait");
  endtask

  task automatic test_branch_wrap();
    clear_program();
    mem[0]     = 16'h303F;  // GOTO 0x3F
    mem[8'h3F] = 16'h0000;
    do_reset();
    run_prog(2, "goto");
    clear_program();
    mem[0]     = 16'h30FF;  // GOTO 0xFF
    mem[8'hFF] = 16'h2077;  // non-branch at top of memory wraps to 0
    mem[0]     = 16'h30FF;
    do_reset();
    run_prog(3, "wrap");
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) begin
      mem[i]   = {4'($urandom_range(0, 5)), 12'($urandom)};
      waits[i] = $urandom_range(0, 3);
    end
    do_reset();
    run_prog(40, "rand");
  endtask

  task automatic test_reset_mid();
    clear_program();
    mem[0]   = 16'h0000;
    mem[1]   = 16'h1055;
    waits[1] = 5;
    do_reset();
    @(negedge clk);
    run = 1'b1;
    repeat (5) @(negedge clk);  // NOP retires, now stalled fetching PC 1
    vectors++;
    if (mem_req !== 1'b1 || pc !== 8'h01) begin
      miscompares++;
      $display("FAIL midrst_pre_fetch: got req=%b pc=%0h want 1 01", mem_req, pc);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || pc !== 8'h00 || reg_wr_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_fetch: got req=%b busy=%b pc=%0h rs=%b want 0 0 00 0",
               mem_req, busy, pc, reg_wr_strobe);
    end
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    waits[1] = 0;
    @(negedge clk);
    run = 1'b1;
    repeat (6) @(negedge clk);  // EXEC of ADD at PC 1
    vectors++;
    if (reg_wr_strobe !== 1'b1 || stat_wr_strobe !== 1'b1 || pc !== 8'h01) begin
      miscompares++;
      $display("FAIL midrst_pre_exec: got rs=%b ss=%b pc=%0h want 1 1 01",
               reg_wr_strobe, stat_wr_strobe, pc);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (reg_wr_strobe !== 1'b0 || stat_wr_strobe !== 1'b0 || instr_done !== 1'b0 ||
        pc !== 8'h00 || instruction !== 16'h0000) begin
      miscompares++;
      $display("FAIL midrst_exec: got rs=%b ss=%b done=%b pc=%0h ir=%0h want 0 0 0 00 0000",
               reg_wr_strobe, stat_wr_strobe, instr_done, pc, instruction);
    end
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (pc !== 8'h00 || busy !== 1'b0 || reg_wr_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_after: got pc=%0h busy=%b rs=%b want 00 0 0", pc, busy, reg_wr_strobe);
    end
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    int dones;
    clear_program();
    do_reset();
    @(negedge clk);
    step  = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (instr_done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 1 || pc !== 8'h01 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL step_held: got dones=%0d pc=%0h busy=%b want 1 01 0", dones, pc, busy);
    end
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step  = 1'b0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (instr_done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 1 || pc !== 8'h02 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL step_pulse: got dones=%0d pc=%0h busy=%b want 1 02 0", dones, pc, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_branch_wrap();
    test_random();
    test_reset_mid();
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
